fadd_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one combinational single-precision float adder among NUM_REQ requesters. It arbitrates among valid requests and registers the winner's operands onto the adder's inputs. It then captures the adder result and returns it on a single tagged response port under valid/ready backpressure. It sits between the compute clients and the shared floating-point add datapath. It owns all sequencing of that datapath, so clients never drive the adder directly.

---
 rtl/fadd_rr_scheduler.sv | 122 ++++++++++++
 tb/tb_fadd_rr_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_rr_scheduler.sv
// Round-robin scheduler that shares one combinational fp32 adder among NUM_REQ requesters.
// It registers the winner's operands, captures the sum and returns it on a tagged valid/ready port.
module fadd_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy,
  output logic [15:0]           ops_done
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SUM_W  = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_r;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic [SUM_W-1:0] scan_idx;
  logic             accept;
  logic             handshake;

  // First valid requester at or after ptr, wrapping with a compare so non-power-of-two counts work.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = SUM_W'(ptr) + SUM_W'(k);
      if (scan_idx >= SUM_W'(NUM_REQ)) begin
        scan_idx = scan_idx - SUM_W'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  assign accept    = |(req_valid & req_ready);
  assign handshake = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grants are offered only from IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (rst_n && grant_found) req_ready[grant_idx] = 1'b1;
      end
      ISSUE:   rsp_valid = 1'b0;
      RESP:    rsp_valid = 1'b1;
      default: rsp_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      id_r     <= '0;
      add_a    <= '0;
      add_b    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      ops_done <= '0;
    end else begin
      if (accept) begin
        add_a <= req_a[DATA_W*grant_idx +: DATA_W];
        add_b <= req_b[DATA_W*grant_idx +: DATA_W];
        id_r  <= grant_idx;
        ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      if (state == ISSUE) begin
        rsp_data <= add_out;
        rsp_id   <= id_r;
      end
      if (handshake) begin
        ops_done <= ops_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fadd_rr_scheduler.sv
// Bench for fadd_rr_scheduler: timeline model checked every cycle plus directed literal checks,
// and a second NUM_REQ=3 instance for the non-power-of-two pointer wrap.
module tb_fadd_rr_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0] add_a, add_b, add_out;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [15:0] ops_done;

  logic        rst3;
  logic [2:0]  req_valid3, req_ready3;
  logic [95:0] req_a3, req_b3;
  logic [31:0] add_a3, add_b3, add_out3;
  logic        rsp_valid3, rsp_ready3;
  logic [31:0] rsp_data3;
  logic [1:0]  rsp_id3;
  logic        busy3;
  logic [15:0] ops_done3;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared fp adder: exact for the directed vectors, arbitrary otherwise.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h3FC00000 && b == 32'hBF000000) return 32'h3F800000;
    return a + b;
  endfunction

  assign add_out  = fadd(add_a, add_b);
  assign add_out3 = fadd(add_a3, add_b3);

  fadd_rr_scheduler #(.NUM_REQ(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .ops_done(ops_done)
  );

  fadd_rr_scheduler #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .rst_n(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .add_a(add_a3), .add_b(add_b3), .add_out(add_out3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_id(rsp_id3),
    .busy(busy3), .ops_done(ops_done3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: an op is in flight for two cycles after accept, then waits for rsp_ready.
  bit          m_ok = 1'b0;
  bit          m_busy = 1'b0;
  int          m_age = 0;
  int          m_ptr = 0;
  int          m_id = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [15:0] m_ops = '0;
  int          cycle = 0;
  int          grant_q[$];
  int          gtime_q[$];

  always @(negedge clk) begin
    int         g;
    logic [3:0] e_ready;
    bit         e_rsp;
    cycle++;
    g = -1;
    if (!m_busy)
      for (int k = 0; k < 4; k++)
        if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    e_ready = '0;
    if (rst_n && g >= 0) e_ready[g] = 1'b1;
    e_rsp = m_busy && (m_age >= 1);
    if (m_ok) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      if (e_rsp) begin
        chk("rsp_data", rsp_data, fadd(m_a, m_b));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
      end
      chk("add_a", add_a, m_a);
      chk("add_b", add_b, m_b);
      chk("ops_done", 32'(ops_done), 32'(m_ops));
    end
    if (!rst_n) begin
      m_ok = 1'b1; m_busy = 1'b0; m_age = 0; m_ptr = 0; m_id = 0;
      m_a = '0; m_b = '0; m_ops = '0;
      grant_q.delete(); gtime_q.delete();
    end else if (m_ok) begin
      if (!m_busy && g >= 0) begin
        m_busy = 1'b1; m_age = 0; m_id = g;
        m_a = req_a[32*g +: 32]; m_b = req_b[32*g +: 32];
        m_ptr = (g + 1) % 4;
        grant_q.push_back(g); gtime_q.push_back(cycle);
      end else if (m_busy && m_age == 0) begin
        m_age = 1;
      end else if (m_busy && rsp_ready) begin
        m_busy = 1'b0;
        m_ops  = m_ops + 16'd1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    rst3 = 1'b0; req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;
    cyc(2);
    rst_n = 1'b1;

    // Single request from requester 2: 1.0 + 2.0
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'h3F800000;
    req_b[64 +: 32] = 32'h40000000;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h4);
    cyc(1);
    req_valid = '0;
    @(negedge clk);
    chk("single_issue_valid", 32'(rsp_valid), 32'h0);
    cyc(1);
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_data", rsp_data, 32'h40400000);
    chk("single_rsp_id", 32'(rsp_id), 32'h2);
    cyc(1);
    @(negedge clk);
    chk("single_ops_done", 32'(ops_done), 32'h1);

    // Full contention from reset; req_ready must stay low while reset is asserted
    cyc(1);
    rst_n = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'(i + 1);
      req_b[32*i +: 32] = 32'(16 * (i + 1));
    end
    @(negedge clk);
    chk("reset_ready_forced", 32'(req_ready), 32'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(13);
    req_valid = '0;
    if (grant_q.size() < 5) begin
      chk("contention_grants", 32'(grant_q.size()), 32'd5);
    end else begin
      for (int i = 0; i < 5; i++) chk("contention_order", 32'(grant_q[i]), 32'(i % 4));
      for (int i = 0; i < 4; i++) chk("contention_spacing", 32'(gtime_q[i+1] - gtime_q[i]), 32'd3);
    end
    cyc(3);

    // Backpressure on requester 1: 1.5 + -0.5, requester 0 waiting meanwhile
    req_valid = 4'b0010;
    req_a[32 +: 32] = 32'h3FC00000;
    req_b[32 +: 32] = 32'hBF000000;
    rsp_ready = 1'b0;
    cyc(1);
    req_valid = 4'b0001;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_data", rsp_data, 32'h3F800000);
      chk("bp_id", 32'(rsp_id), 32'h1);
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_ops_hold", 32'(ops_done), 32'd5);
      cyc(1);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    cyc(1);
    @(negedge clk);
    chk("bp_ops_after", 32'(ops_done), 32'd6);
    chk("bp_valid_after", 32'(rsp_valid), 32'h0);

    // Reset while a response is pending from requester 3
    cyc(1);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    cyc(1);
    req_valid = '0;
    cyc(1);
    @(negedge clk);
    chk("rst_resp_pending", 32'(rsp_valid), 32'h1);
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
      chk("rst_ops", 32'(ops_done), 32'h0);
      chk("rst_add_a", add_a, 32'h0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      cyc(1);
    end
    req_valid = 4'b0011;
    @(negedge clk);
    chk("rst_ptr_zero_grant", 32'(req_ready), 32'h1);
    cyc(1);
    req_valid = '0;
    cyc(3);

    // ops_done wrap: preload 0xFFFF, then one handshake
    @(negedge clk);
    #1;
    force u_dut.ops_done = 16'hFFFF;
    #1;
    release u_dut.ops_done;
    m_ops = 16'hFFFF;
    cyc(1);
    req_valid = 4'b0100;
    cyc(1);
    req_valid = '0;
    cyc(1);
    @(negedge clk);
    chk("wrap_before", 32'(ops_done), 32'hFFFF);
    cyc(1);
    @(negedge clk);
    chk("wrap_after", 32'(ops_done), 32'h0);

    // NUM_REQ=3: leave ptr at 2, then requesters 1 and 2 contend
    cyc(1);
    rst3 = 1'b1;
    req_valid3 = 3'b010;
    cyc(1);
    req_valid3 = 3'b110;
    cyc(2);
    @(negedge clk);
    chk("n3_grant_2", 32'(req_ready3), 32'h4);
    cyc(2);
    @(negedge clk);
    chk("n3_rsp_valid", 32'(rsp_valid3), 32'h1);
    chk("n3_rsp_id", 32'(rsp_id3), 32'h2);
    cyc(1);
    @(negedge clk);
    chk("n3_wrap_grant_1", 32'(req_ready3), 32'h2);
    req_valid3 = '0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
